dpram_access_arbiter: RTL and testbench
=======================================

Name: dpram_access_arbiter

Overview:
- Shares the two ports (A, B) of the 8x8 dual-port RAM between NUM_REQ requesters; each requester issues single-beat read or write transactions.
- Round-robin arbitration: up to two grants per cycle, one per RAM port.
- Resolves same-address write/write conflicts and rejects out-of-range addresses.
- Registers all RAM-side signals and returns read data with a fixed latency and a per-requester valid strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DEPTH, 8, number of valid RAM words; an address >= DEPTH is out of range.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester request; held until granted.
- we_i  in  NUM_REQ  1 = write, 0 = read; stable while req_i is high.
- addr_i  in  8*NUM_REQ  per-requester address; requester k uses bits [8k+7:8k].
- wdata_i  in  8*NUM_REQ  per-requester write data.
- gnt_o  out  NUM_REQ  combinational grant; the transaction is accepted at the clock edge where req_i & gnt_o.
- rvalid_o  out  NUM_REQ  one-cycle read-data strobe.
- rdata_o  out  8*NUM_REQ  read data, qualified by rvalid_o.
- err_o  out  NUM_REQ  one-cycle pulse: accepted request had an out-of-range address.
- ram_we_a, ram_we_b  out  1  RAM write enables (registered).
- ram_addr_a, ram_addr_b  out  8  RAM addresses (registered).
- ram_din_a, ram_din_b  out  8  RAM write data (registered).
- ram_dout_a, ram_dout_b  in  8  RAM read data (registered inside the RAM).

Behaviour:
- Reset (reset_n low at an edge): rr_ptr = 0; all ram_* outputs = 0; rvalid_o = 0; err_o = 0; rdata_o = 0; pipeline tags cleared. Reset mid-transaction drops in-flight reads: no rvalid_o is issued for them.
- Arbitration (combinational):
  - Scan requesters from rr_ptr upward, wrapping modulo NUM_REQ.
  - First pending requester goes to port A; second goes to port B.
  - gnt_o is high only for these two requesters.
- Write/write conflict: both selected requests are writes to the same address -> port A requester granted, port B requester not granted this cycle and its request stays pending. Port B is then offered to the next pending requester in scan order, if that one does not conflict.
- Read/write to the same address in the same cycle: both granted; the read returns the old data.
- Pointer update: on any accepted grant, rr_ptr = (index of last granted requester + 1) mod NUM_REQ. No grant -> rr_ptr holds.
- Issue, at acceptance edge E:
  - Port registers load we, addr and wdata from the granted requester.
  - Out of range: we forced 0, addr forced 0, err_o[k] = 1 for the cycle after E, and no read is tagged.
  - Idle port: we = 0, addr holds.
- Read return:
  - RAM captures at E+1; rvalid_o[k] is high for exactly the cycle after edge E+1.
  - rdata_o[k] = the tagged port's ram_dout; rdata_o holds its value between strobes.
  - Read latency from acceptance = 2 cycles.
  - Writes produce no rvalid_o.
- Throughput: back-to-back grants every cycle, two per cycle maximum; the pipeline never stalls.
- A requester is granted at most once per cycle. Never-granted starvation is impossible: any pending requester is granted within NUM_REQ cycles.

Optional Feature:
- Macro ARB_COLLISION_CNT_EN.
- Defined:
  - Adds output coll_cnt_o [15:0], reset to 0.
  - Increments by 1 for every cycle in which a write/write conflict denied a grant.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; arbitration is identical.

Test Plan:
- Reset: drive reset_n = 0 with req_i = 4'hF -> gnt_o ignored at the edge; after release, all ram_* = 0, rvalid_o = 0, rr_ptr = 0.
- Single write then read:
  - req0 writes 8'hA5 to addr 3 -> ram_we_a = 1, ram_addr_a = 3 one cycle later.
  - req0 then reads addr 3 -> rvalid_o[0] two cycles after acceptance, with rdata_o[7:0] = 8'hA5.
- Round-robin: req_i = 4'hF held with reads -> grants {0,1}, {2,3}, {0,1}, ... on successive cycles; each rvalid_o lands 2 cycles after its grant.
- Write conflict:
  - req1 and req2 both write addr 5 (8'h11 and 8'h22) with rr_ptr = 1 -> only req1 granted; req2 granted the next cycle.
  - Final read of addr 5 returns 8'h22.
  - With ARB_COLLISION_CNT_EN, coll_cnt_o = 1.
- Out of range: req3 reads addr 8'h09 -> granted; err_o[3] pulses one cycle; no rvalid_o[3]; ram_we = 0.
- Reset mid-read: accept a read on req2, assert reset_n = 0 on the next edge -> no rvalid_o[2]; all outputs at reset values.

Source files
------------

// File: rtl/dpram_access_arbiter.sv
// rtl/dpram_access_arbiter.sv - round-robin sharing of a dual-port RAM between NUM_REQ requesters
//
// Purpose: grants up to two single-beat transactions per cycle (one per RAM
// port), settles same-address write/write conflicts in favour of port A,
// rejects out-of-range addresses, registers every RAM-side signal and returns
// read data two cycles after acceptance with a per-requester strobe.
//
// Ports:
//   clk, reset_n          single clock, synchronous active-low reset
//   req_i/we_i            per-requester request and direction (1 = write)
//   addr_i/wdata_i        per-requester address/write data, 8 bits each
//   gnt_o                 combinational grant; accepted where req_i & gnt_o
//   rvalid_o/rdata_o      read-data strobe and data (data holds between strobes)
//   err_o                 one-cycle pulse for an accepted out-of-range address
//   ram_*_a/ram_*_b       registered RAM controls, RAM read data inputs
//   coll_cnt_o            saturating write/write conflict counter, present
//                         only when ARB_COLLISION_CNT_EN is defined
module dpram_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   we_i,
  input  logic [8*NUM_REQ-1:0] addr_i,
  input  logic [8*NUM_REQ-1:0] wdata_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   rvalid_o,
  output logic [8*NUM_REQ-1:0] rdata_o,
  output logic [NUM_REQ-1:0]   err_o,
  output logic                 ram_we_a,
  output logic                 ram_we_b,
  output logic [7:0]           ram_addr_a,
  output logic [7:0]           ram_addr_b,
  output logic [7:0]           ram_din_a,
  output logic [7:0]           ram_din_b,
  input  logic [7:0]           ram_dout_a,
  input  logic [7:0]           ram_dout_b
`ifdef ARB_COLLISION_CNT_EN
  ,
  output logic [15:0]          coll_cnt_o
`endif
);

  localparam int            PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [8:0]    DEPTH_V = 9'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][7:0] addr_v;
  logic [NUM_REQ-1:0][7:0] wdata_v;
  logic [NUM_REQ-1:0][7:0] rdata_v;
  logic [NUM_REQ-1:0][7:0] rdata_q;

  assign addr_v  = addr_i;
  assign wdata_v = wdata_i;
  assign rdata_o = rdata_v;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      sel_a;
  logic [PW-1:0]      sel_b;
  logic [PW-1:0]      idx;
  logic               sel_a_vld;
  logic               sel_b_vld;
  logic               conflict;
  logic [NUM_REQ-1:0] rd_tag;   // read accepted last edge, RAM samples next edge
  logic [NUM_REQ-1:0] rd_port;  // 1 = that read went out on port B
  logic [NUM_REQ-1:0] rport_q;  // port of the read being returned now

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] s);
    return (s == LAST) ? '0 : s + 1'b1;
  endfunction

  // Scan from rr_ptr: first pending requester takes port A; later pending
  // requesters are offered port B unless they write the same in-range address
  // as the port A write, in which case they wait and the scan moves on.
  always_comb begin : arbitrate
    sel_a_vld = 1'b0;
    sel_b_vld = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    conflict  = 1'b0;
    gnt_o     = '0;
    idx       = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[idx]) begin
        if (!sel_a_vld) begin
          sel_a_vld = 1'b1;
          sel_a     = idx;
        end else if (!sel_b_vld) begin
          if (we_i[sel_a] && we_i[idx] && (addr_v[sel_a] == addr_v[idx]) &&
              in_range(addr_v[idx])) begin
            conflict = 1'b1;
          end else begin
            sel_b_vld = 1'b1;
            sel_b     = idx;
          end
        end
      end
      idx = wrap_inc(idx);
    end
    if (sel_a_vld) gnt_o[sel_a] = 1'b1;
    if (sel_b_vld) gnt_o[sel_b] = 1'b1;
  end

  // During the strobe cycle data comes straight from the RAM; afterwards the
  // captured copy is presented so rdata_o holds between strobes.
  always_comb begin : read_mux
    rdata_v = rdata_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rvalid_o[k]) rdata_v[k] = rport_q[k] ? ram_dout_b : ram_dout_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      ram_we_a   <= 1'b0;
      ram_we_b   <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_din_a  <= '0;
      ram_din_b  <= '0;
      rd_tag     <= '0;
      rd_port    <= '0;
      rport_q    <= '0;
      rvalid_o   <= '0;
      err_o      <= '0;
      rdata_q    <= '0;
`ifdef ARB_COLLISION_CNT_EN
      coll_cnt_o <= '0;
`endif
    end else begin
      ram_we_a <= 1'b0;
      ram_we_b <= 1'b0;
      err_o    <= '0;
      rd_tag   <= '0;

      if (sel_a_vld) begin
        if (in_range(addr_v[sel_a])) begin
          ram_we_a       <= we_i[sel_a];
          ram_addr_a     <= addr_v[sel_a];
          ram_din_a      <= wdata_v[sel_a];
          rd_tag[sel_a]  <= ~we_i[sel_a];
          rd_port[sel_a] <= 1'b0;
        end else begin
          ram_addr_a   <= '0;
          err_o[sel_a] <= 1'b1;
        end
      end

      if (sel_b_vld) begin
        if (in_range(addr_v[sel_b])) begin
          ram_we_b       <= we_i[sel_b];
          ram_addr_b     <= addr_v[sel_b];
          ram_din_b      <= wdata_v[sel_b];
          rd_tag[sel_b]  <= ~we_i[sel_b];
          rd_port[sel_b] <= 1'b1;
        end else begin
          ram_addr_b   <= '0;
          err_o[sel_b] <= 1'b1;
        end
      end

      // Port B, when granted, always lies later in scan order than port A.
      if (sel_b_vld)      rr_ptr <= wrap_inc(sel_b);
      else if (sel_a_vld) rr_ptr <= wrap_inc(sel_a);

      rvalid_o <= rd_tag;
      rport_q  <= rd_port;
      rdata_q  <= rdata_v;

`ifdef ARB_COLLISION_CNT_EN
      if (conflict && (coll_cnt_o != 16'hFFFF)) coll_cnt_o <= coll_cnt_o + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// tb/tb_dpram_access_arbiter.sv - directed and randomized self-checking bench for dpram_access_arbiter
module tb_dpram_access_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, we;
  logic [8*N-1:0] addr, wdata;
  logic [N-1:0]   gnt_o, rvalid_o, err_o;
  logic [8*N-1:0] rdata_o;
  logic           ram_we_a, ram_we_b;
  logic [7:0]     ram_addr_a, ram_addr_b, ram_din_a, ram_din_b;
  logic [7:0]     ram_dout_a, ram_dout_b;
`ifdef ARB_COLLISION_CNT_EN
  logic [15:0]    coll_cnt_o;
`endif

  always #5 clk = ~clk;

  dpram_access_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
`ifdef ARB_COLLISION_CNT_EN
    , .coll_cnt_o(coll_cnt_o)
`endif
  );

  // Behavioural 8x8 dual-port RAM, read-first on both ports.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    ram_dout_a <= mem[ram_addr_a[2:0]];
    ram_dout_b <= mem[ram_addr_b[2:0]];
    if (ram_we_a) mem[ram_addr_a[2:0]] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b[2:0]] <= ram_din_b;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int         m_ptr;
  logic [7:0] ref_mem [DEPTH];
  logic [N-1:0] st_rv;
  logic [7:0] st_data [N];
  logic [7:0] e_rdata [N];
  logic [N-1:0] e_rv, e_err;
  logic       e_we   [2];
  logic [7:0] e_addr [2];
  logic [7:0] e_din  [2];
  int         e_coll;

  function automatic logic [7:0] ad(input int k);
    return addr[8*k +: 8];
  endfunction

  function automatic logic [7:0] wd(input int k);
    return wdata[8*k +: 8];
  endfunction

  task automatic setr(input int k, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    req[k] = r;
    we[k] = w;
    addr[8*k +: 8] = a;
    wdata[8*k +: 8] = d;
  endtask

  // One clock: inputs already applied at a negedge; checks the grant, advances
  // the model, then checks every registered output after the edge.
  task automatic step(input bit rst, output logic [N-1:0] acc, output logic [N-1:0] g_obs);
    int order[$];
    int sel[2];
    bit confl;
    logic [N-1:0] g;
    logic [N-1:0] nst;
    logic [7:0] nd [N];
    logic [8*N-1:0] er;
    reset_n = !rst;
    #1;
    g_obs = gnt_o;
    g = '0;
    sel[0] = -1;
    sel[1] = -1;
    confl = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (req[k]) order.push_back(k);
    end
    if (order.size() > 0) begin
      sel[0] = order[0];
      for (int j = 1; j < order.size(); j++) begin
        int k = order[j];
        if (we[sel[0]] && we[k] && ad(sel[0]) == ad(k) && ad(k) < DEPTH) confl = 1'b1;
        else begin
          sel[1] = k;
          break;
        end
      end
    end
    for (int p = 0; p < 2; p++) if (sel[p] >= 0) g[sel[p]] = 1'b1;
    acc = rst ? '0 : g;
    if (!rst) check("gnt", g_obs, g);

    if (rst) begin
      m_ptr = 0;
      st_rv = '0;
      e_rv = '0;
      e_err = '0;
      e_coll = 0;
      for (int k = 0; k < N; k++) e_rdata[k] = 8'h00;
      for (int p = 0; p < 2; p++) begin
        e_we[p] = 1'b0;
        e_addr[p] = 8'h00;
        e_din[p] = 8'h00;
      end
    end else begin
      e_rv = st_rv;
      for (int k = 0; k < N; k++) if (st_rv[k]) e_rdata[k] = st_data[k];
      nst = '0;
      e_err = '0;
      for (int k = 0; k < N; k++) nd[k] = 8'h00;
      for (int p = 0; p < 2; p++) begin
        int k = sel[p];
        e_we[p] = 1'b0;
        if (k >= 0) begin
          if (ad(k) < DEPTH) begin
            e_we[p] = we[k];
            e_addr[p] = ad(k);
            if (we[k]) e_din[p] = wd(k);
            else begin
              nst[k] = 1'b1;
              nd[k] = ref_mem[ad(k)];
            end
          end else begin
            e_addr[p] = 8'h00;
            e_err[k] = 1'b1;
          end
        end
      end
      for (int p = 0; p < 2; p++) if (e_we[p]) ref_mem[e_addr[p]] = e_din[p];
      st_rv = nst;
      for (int k = 0; k < N; k++) st_data[k] = nd[k];
      if (sel[1] >= 0) m_ptr = (sel[1] + 1) % N;
      else if (sel[0] >= 0) m_ptr = (sel[0] + 1) % N;
      if (confl && e_coll < 65535) e_coll++;
    end

    @(posedge clk);
    @(negedge clk);
    check("ram_we_a", ram_we_a, e_we[0]);
    check("ram_we_b", ram_we_b, e_we[1]);
    check("ram_addr_a", ram_addr_a, e_addr[0]);
    check("ram_addr_b", ram_addr_b, e_addr[1]);
    if (e_we[0] || rst) check("ram_din_a", ram_din_a, e_din[0]);
    if (e_we[1] || rst) check("ram_din_b", ram_din_b, e_din[1]);
    check("rvalid", rvalid_o, e_rv);
    check("err", err_o, e_err);
    for (int k = 0; k < N; k++) er[8*k +: 8] = e_rdata[k];
    check("rdata", rdata_o, er);
`ifdef ARB_COLLISION_CNT_EN
    check("coll_cnt", coll_cnt_o, e_coll);
`endif
  endtask

  logic [N-1:0] acc, g;
  int waitc [N];
  bit rst;

  initial begin
    reset_n = 1'b0;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    @(negedge clk);

    // Reset with all requests pending
    req = '1;
    step(1, acc, g);
    step(1, acc, g);
    check("rst_ram_we_a", ram_we_a, 1'b0);
    check("rst_rvalid", rvalid_o, 4'h0);
    req = '0;
    step(0, acc, g);

    // Single write then read by requester 0
    setr(0, 1, 1, 8'd3, 8'hA5);
    step(0, acc, g);
    check("wr_we_a", ram_we_a, 1'b1);
    check("wr_addr_a", ram_addr_a, 8'd3);
    setr(0, 1, 0, 8'd3, 8'h00);
    step(0, acc, g);
    setr(0, 0, 0, 8'd0, 8'h00);
    step(0, acc, g);
    check("rd_rvalid0", rvalid_o[0], 1'b1);
    check("rd_data0", rdata_o[7:0], 8'hA5);

    // Round robin from a fresh pointer, all requesters reading continuously
    step(1, acc, g);
    for (int k = 0; k < N; k++) setr(k, 1, 0, 8'(k), 8'h00);
    for (int c = 0; c < 4; c++) begin
      step(0, acc, g);
      check("rr_gnt", g, (c % 2) ? 4'b1100 : 4'b0011);
    end
    req = '0;
    step(0, acc, g);
    step(0, acc, g);

    // Write/write conflict with rr_ptr = 1
    setr(0, 1, 0, 8'd0, 8'h00);
    step(0, acc, g);
    req = '0;
    setr(1, 1, 1, 8'd5, 8'h11);
    setr(2, 1, 1, 8'd5, 8'h22);
    step(0, acc, g);
    check("conf_gnt1", g, 4'b0010);
    req[1] = 1'b0;
    step(0, acc, g);
    check("conf_gnt2", g, 4'b0100);
`ifdef ARB_COLLISION_CNT_EN
    check("conf_cnt", coll_cnt_o, 16'd1);
`endif
    req = '0;
    setr(0, 1, 0, 8'd5, 8'h00);
    step(0, acc, g);
    req = '0;
    step(0, acc, g);
    check("conf_rdata", rdata_o[7:0], 8'h22);

    // Out-of-range read on requester 3
    setr(3, 1, 0, 8'h09, 8'h00);
    step(0, acc, g);
    check("oor_gnt3", g[3], 1'b1);
    check("oor_err", err_o, 4'b1000);
    check("oor_we_a", ram_we_a, 1'b0);
    req = '0;
    step(0, acc, g);
    check("oor_rvalid3", rvalid_o[3], 1'b0);

    // Reset while a read from requester 2 is in flight
    setr(2, 1, 0, 8'd1, 8'h00);
    step(0, acc, g);
    req = '0;
    step(1, acc, g);
    check("rst_mid_rvalid", rvalid_o, 4'h0);
    step(0, acc, g);
    check("rst_mid_rvalid2", rvalid_o[2], 1'b0);

    // Randomized traffic with requests held until granted
    for (int k = 0; k < N; k++) waitc[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 2) != 0)
          setr(k, 1, 1'($urandom % 2), ($urandom % 2) ? 8'd5 : 8'($urandom_range(0, 9)), 8'($urandom));
      end
      rst = ((c % 97) == 96);
      step(rst, acc, g);
      for (int k = 0; k < N; k++) begin
        if (acc[k] || rst) begin
          if (acc[k]) req[k] = 1'b0;
          waitc[k] = 0;
        end else if (req[k]) begin
          waitc[k]++;
          check("wait_bound", waitc[k] <= 2 * N, 1'b1);
        end
      end
    end
    req = '0;
    step(0, acc, g);
    step(0, acc, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
